// File: rtl/mem_pkg.sv
// Shared constants for the data-memory arbiter: access size codes, FSM
// state encoding and the default starvation limit.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [0:0] P_OWN = 1'b0;
    localparam logic [0:0] D_OWN = 1'b1;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the pipeline, debug-loader and data-memory buses around the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if;

    logic        p_req;
    logic        p_we;
    logic [1:0]  p_len;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_stall;
    logic [31:0] p_rdata;
    logic        p_err;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_len;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        m_we;
    logic [1:0]  m_len;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    modport slave (
        input  p_req, p_we, p_len, p_addr, p_wdata,
        input  d_req, d_we, d_len, d_addr, d_wdata,
        input  m_rdata,
        output p_stall, p_rdata, p_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_we, m_len, m_addr, m_wdata
    );

    modport master (
        output p_req, p_we, p_len, p_addr, p_wdata,
        output d_req, d_we, d_len, d_addr, d_wdata,
        output m_rdata,
        input  p_stall, p_rdata, p_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_we, m_len, m_addr, m_wdata
    );

endinterface

// File: rtl/align_check.sv
// Flags a half access on an odd address or a word access not on a 4-byte
// boundary; size code 11 is handled as a word.
module align_check
    import mem_pkg::*;
(
    input  logic [1:0] i_len,
    input  logic [1:0] i_addr_lo,
    output logic       o_misaligned
);

    always_comb begin
        case (i_len)
            SZ_BYTE: o_misaligned = 1'b0;
            SZ_HALF: o_misaligned = i_addr_lo[0];
            default: o_misaligned = |i_addr_lo;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data-memory port between the MEM pipeline stage and a debug
// loader; the pipeline has priority, a starved debug request forces one cycle.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    logic        w_p_req;
    logic        w_d_req;
    logic        w_p_mis;
    logic        w_d_mis;
    logic        w_d_gnt;
    logic        w_starve_hit;

    logic [0:0]  r_state;
    logic [3:0]  r_starve;
    logic        r_d_rvalid;
    logic [31:0] r_d_rdata;
    logic        r_d_err;

    // Requests are masked during reset so the combinational outputs look idle.
    assign w_p_req = bus.p_req & rst;
    assign w_d_req = bus.d_req & rst;

    align_check u_p_align (
        .i_len        (bus.p_len),
        .i_addr_lo    (bus.p_addr[1:0]),
        .o_misaligned (w_p_mis)
    );

    align_check u_d_align (
        .i_len        (bus.d_len),
        .i_addr_lo    (bus.d_addr[1:0]),
        .o_misaligned (w_d_mis)
    );

    // Forcing on the cycle the count reaches STARVE_MAX gives exactly
    // STARVE_MAX pipeline cycles between forced grants.
    assign w_starve_hit = (r_starve >= 4'(STARVE_MAX - 1));

    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        bus.m_we    = 1'b0;
        bus.m_len   = bus.p_len;
        bus.m_addr  = bus.p_addr;
        bus.m_wdata = bus.p_wdata;
        bus.p_stall = 1'b0;
        bus.p_rdata = '0;
        bus.p_err   = 1'b0;
        w_d_gnt     = 1'b0;
        if (r_state == P_OWN) begin
            bus.p_rdata = bus.m_rdata;
            bus.p_err   = w_p_req & w_p_mis;
            if (w_p_req) begin
                bus.m_we = bus.p_we & ~w_p_mis;
            end else if (w_d_req) begin
                bus.m_len   = bus.d_len;
                bus.m_addr  = bus.d_addr;
                bus.m_wdata = bus.d_wdata;
                bus.m_we    = bus.d_we & ~w_d_mis;
                w_d_gnt     = 1'b1;
            end
        end else begin
            bus.m_len   = bus.d_len;
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
            bus.m_we    = w_d_req & bus.d_we & ~w_d_mis;
            bus.p_stall = w_p_req;
            w_d_gnt     = w_d_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= P_OWN;
            r_starve   <= '0;
            r_d_rvalid <= 1'b0;
            r_d_rdata  <= '0;
            r_d_err    <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // updates from the same pre-edge values.
            if (r_state == P_OWN) begin
                if (w_p_req && w_d_req) begin
                    if (w_starve_hit) begin
                        r_state  <= D_OWN;
                        r_starve <= 4'(STARVE_MAX);
                    end else begin
                        r_starve <= r_starve + 4'd1;
                    end
                end else begin
                    r_starve <= '0;
                end
            end else begin
                r_state  <= P_OWN;
                r_starve <= '0;
            end
            r_d_rvalid <= w_d_gnt;
            r_d_err    <= w_d_gnt & w_d_mis;
            r_d_rdata  <= (w_d_gnt && !bus.d_we) ? bus.m_rdata : '0;
        end
    end

    assign bus.d_gnt    = w_d_gnt;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.d_err    = r_d_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a word-indexed behavioural data memory.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;
    logic [31:0] mem [0:63];
    int          n_vec;
    int          n_err;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.m_rdata = mem[bus.m_addr[7:2]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        if (bus.m_we) mem[bus.m_addr[7:2]] <= bus.m_wdata;
    end

    task automatic set_idle();
        bus.p_req = 0; bus.p_we = 0; bus.p_len = 2'b10; bus.p_addr = '0; bus.p_wdata = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_len = 2'b10; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        set_idle();
        @(posedge clk);
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1; pre_idx = idx; pre_data = data;
        @(posedge clk);
        #1 pre_we = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        set_idle();
        bus.p_req = 1; bus.p_we = 1; bus.p_addr = 32'h22;
        bus.d_req = 1; bus.d_we = 1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.m_we !== 1'b0) begin n_err++; $display("FAIL rst_m_we: got %0b want 0", bus.m_we); end
        n_vec++; if (bus.d_gnt !== 1'b0) begin n_err++; $display("FAIL rst_d_gnt: got %0b want 0", bus.d_gnt); end
        n_vec++; if (bus.p_stall !== 1'b0) begin n_err++; $display("FAIL rst_p_stall: got %0b want 0", bus.p_stall); end
        n_vec++; if (bus.p_err !== 1'b0) begin n_err++; $display("FAIL rst_p_err: got %0b want 0", bus.p_err); end
        n_vec++; if (bus.d_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_d_rvalid: got %0b want 0", bus.d_rvalid); end
        n_vec++; if (bus.d_rdata !== 32'h0) begin n_err++; $display("FAIL rst_d_rdata: got %h want 0", bus.d_rdata); end
        n_vec++; if (bus.d_err !== 1'b0) begin n_err++; $display("FAIL rst_d_err: got %0b want 0", bus.d_err); end
        @(negedge clk);
        set_idle();
        rst = 1;
        @(posedge clk);
    endtask

    task automatic test_pipe_load();
        preload(6'd4, 32'hDEADBEEF);
        @(negedge clk);
        bus.p_req = 1; bus.p_we = 0; bus.p_len = 2'b10; bus.p_addr = 32'h10;
        #1;
        n_vec++; if (bus.p_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL pload_rdata: got %h want deadbeef", bus.p_rdata); end
        n_vec++; if (bus.p_stall !== 1'b0) begin n_err++; $display("FAIL pload_stall: got %0b want 0", bus.p_stall); end
        n_vec++; if (bus.d_gnt !== 1'b0) begin n_err++; $display("FAIL pload_gnt: got %0b want 0", bus.d_gnt); end
        n_vec++; if (bus.m_we !== 1'b0) begin n_err++; $display("FAIL pload_m_we: got %0b want 0", bus.m_we); end
        n_vec++; if (bus.m_addr !== 32'h10) begin n_err++; $display("FAIL pload_m_addr: got %h want 10", bus.m_addr); end
        idle_cycle();
    endtask

    task automatic test_idle();
        @(negedge clk);
        set_idle();
        bus.p_addr = 32'h34; bus.d_addr = 32'h20;
        #1;
        n_vec++; if (bus.m_we !== 1'b0) begin n_err++; $display("FAIL idle_m_we: got %0b want 0", bus.m_we); end
        n_vec++; if (bus.m_addr !== 32'h34) begin n_err++; $display("FAIL idle_m_addr: got %h want 34", bus.m_addr); end
        n_vec++; if (bus.d_gnt !== 1'b0) begin n_err++; $display("FAIL idle_gnt: got %0b want 0", bus.d_gnt); end
        idle_cycle();
    endtask

    task automatic test_debug_write();
        @(negedge clk);
        bus.d_req = 1; bus.d_we = 1; bus.d_len = 2'b10; bus.d_addr = 32'h20; bus.d_wdata = 32'h55;
        #1;
        n_vec++; if (bus.d_gnt !== 1'b1) begin n_err++; $display("FAIL dwr_gnt: got %0b want 1", bus.d_gnt); end
        n_vec++; if (bus.m_we !== 1'b1) begin n_err++; $display("FAIL dwr_m_we: got %0b want 1", bus.m_we); end
        n_vec++; if (bus.m_addr !== 32'h20) begin n_err++; $display("FAIL dwr_m_addr: got %h want 20", bus.m_addr); end
        @(posedge clk);
        #1;
        n_vec++; if (mem[8] !== 32'h55) begin n_err++; $display("FAIL dwr_mem: got %h want 55", mem[8]); end
        n_vec++; if (bus.d_rvalid !== 1'b1) begin n_err++; $display("FAIL dwr_rvalid: got %0b want 1", bus.d_rvalid); end
        n_vec++; if (bus.d_rdata !== 32'h0) begin n_err++; $display("FAIL dwr_rdata: got %h want 0", bus.d_rdata); end
        idle_cycle();
        #1;
        n_vec++; if (bus.d_rvalid !== 1'b0) begin n_err++; $display("FAIL dwr_rvalid_pulse: got %0b want 0", bus.d_rvalid); end
    endtask

    task automatic test_debug_read();
        @(negedge clk);
        bus.d_req = 1; bus.d_we = 0; bus.d_len = 2'b11; bus.d_addr = 32'h10;
        @(posedge clk);
        #1;
        n_vec++; if (bus.d_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL drd_rdata: got %h want deadbeef", bus.d_rdata); end
        n_vec++; if (bus.d_rvalid !== 1'b1) begin n_err++; $display("FAIL drd_rvalid: got %0b want 1", bus.d_rvalid); end
        n_vec++; if (bus.d_err !== 1'b0) begin n_err++; $display("FAIL drd_err: got %0b want 0", bus.d_err); end
        idle_cycle();
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        bus.p_req = 1; bus.p_we = 1; bus.p_len = 2'b10; bus.p_addr = 32'h22; bus.p_wdata = 32'hBAD0BAD0;
        #1;
        n_vec++; if (bus.p_err !== 1'b1) begin n_err++; $display("FAIL mis_p_err: got %0b want 1", bus.p_err); end
        n_vec++; if (bus.m_we !== 1'b0) begin n_err++; $display("FAIL mis_p_m_we: got %0b want 0", bus.m_we); end
        @(posedge clk);
        #1;
        n_vec++; if (mem[8] !== 32'h55) begin n_err++; $display("FAIL mis_mem: got %h want 55", mem[8]); end
        @(negedge clk);
        bus.p_we = 0; bus.p_len = 2'b01; bus.p_addr = 32'h22;
        #1;
        n_vec++; if (bus.p_err !== 1'b0) begin n_err++; $display("FAIL mis_half_ok: got %0b want 0", bus.p_err); end
        @(negedge clk);
        set_idle();
        bus.d_req = 1; bus.d_we = 1; bus.d_len = 2'b01; bus.d_addr = 32'h21; bus.d_wdata = 32'h77;
        #1;
        n_vec++; if (bus.m_we !== 1'b0) begin n_err++; $display("FAIL mis_d_wr_m_we: got %0b want 0", bus.m_we); end
        @(negedge clk);
        bus.d_we = 0;
        #1;
        n_vec++; if (bus.d_gnt !== 1'b1) begin n_err++; $display("FAIL mis_d_gnt: got %0b want 1", bus.d_gnt); end
        @(posedge clk);
        #1;
        n_vec++; if (bus.d_rvalid !== 1'b1) begin n_err++; $display("FAIL mis_d_rvalid: got %0b want 1", bus.d_rvalid); end
        n_vec++; if (bus.d_err !== 1'b1) begin n_err++; $display("FAIL mis_d_err: got %0b want 1", bus.d_err); end
        n_vec++; if (mem[8] !== 32'h55) begin n_err++; $display("FAIL mis_d_mem: got %h want 55", mem[8]); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic        exp_gnt;
        logic        exp_rv;
        logic [31:0] exp_prd;
        @(negedge clk);
        bus.p_req = 1; bus.p_we = 0; bus.p_len = 2'b10; bus.p_addr = 32'h10;
        bus.d_req = 1; bus.d_we = 0; bus.d_len = 2'b10; bus.d_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            exp_gnt = (i % 5 == 4);
            exp_rv  = (i % 5 == 0) && (i > 0);
            exp_prd = exp_gnt ? 32'h0 : 32'hDEADBEEF;
            n_vec++; if (bus.d_gnt !== exp_gnt) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %0b want %0b", i, bus.d_gnt, exp_gnt); end
            n_vec++; if (bus.p_stall !== exp_gnt) begin n_err++; $display("FAIL b2b_stall[%0d]: got %0b want %0b", i, bus.p_stall, exp_gnt); end
            n_vec++; if (bus.p_rdata !== exp_prd) begin n_err++; $display("FAIL b2b_prdata[%0d]: got %h want %h", i, bus.p_rdata, exp_prd); end
            n_vec++; if (bus.d_rvalid !== exp_rv) begin n_err++; $display("FAIL b2b_rvalid[%0d]: got %0b want %0b", i, bus.d_rvalid, exp_rv); end
            if (exp_rv) begin
                n_vec++; if (bus.d_rdata !== 32'h55) begin n_err++; $display("FAIL b2b_drdata[%0d]: got %h want 55", i, bus.d_rdata); end
            end
        end
        idle_cycle();
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        bus.p_req = 1; bus.p_we = 0; bus.p_len = 2'b10; bus.p_addr = 32'h10;
        bus.d_req = 1; bus.d_we = 1; bus.d_len = 2'b10; bus.d_addr = 32'h20; bus.d_wdata = 32'hAAAA;
        repeat (4) @(posedge clk);
        #1;
        n_vec++; if (bus.m_we !== 1'b1) begin n_err++; $display("FAIL abort_pre_m_we: got %0b want 1", bus.m_we); end
        rst = 0;
        #1;
        n_vec++; if (bus.m_we !== 1'b0) begin n_err++; $display("FAIL abort_m_we: got %0b want 0", bus.m_we); end
        n_vec++; if (bus.d_gnt !== 1'b0) begin n_err++; $display("FAIL abort_gnt: got %0b want 0", bus.d_gnt); end
        n_vec++; if (bus.p_stall !== 1'b0) begin n_err++; $display("FAIL abort_stall: got %0b want 0", bus.p_stall); end
        @(posedge clk);
        #1;
        n_vec++; if (bus.d_rvalid !== 1'b0) begin n_err++; $display("FAIL abort_rvalid: got %0b want 0", bus.d_rvalid); end
        n_vec++; if (mem[8] !== 32'h55) begin n_err++; $display("FAIL abort_mem: got %h want 55", mem[8]); end
        @(negedge clk);
        bus.d_we = 0;
        rst = 1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            n_vec++; if (bus.d_gnt !== (k == 4)) begin n_err++; $display("FAIL abort_regnt[%0d]: got %0b want %0b", k, bus.d_gnt, (k == 4)); end
            n_vec++; if (bus.d_rvalid !== 1'b0) begin n_err++; $display("FAIL abort_rv[%0d]: got %0b want 0", k, bus.d_rvalid); end
        end
        idle_cycle();
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        pre_we = 0; pre_idx = '0; pre_data = '0;
        test_reset();
        test_pipe_load();
        test_idle();
        test_debug_write();
        test_debug_read();
        test_misaligned();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the debug wait cycles before forced grant (range 1..15).
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 p_req/p_we  in  1/1  MEM-stage access request / write.
REQ-005 p_len  in  2  MEM-stage size; p_addr, p_wdata  in  32  address, store data.
REQ-006 p_stall  out  1  pipeline hold; p_rdata  out  32  load data; p_err  out  1  misaligned access.
REQ-007 d_req/d_we  in  1/1  debug-loader request / write; d_len  in  2; d_addr, d_wdata  in  32.
REQ-008 d_gnt  out  1  debug access issued this cycle; d_rvalid  out  1; d_rdata  out  32; d_err  out  1.
REQ-009 m_we  out  1; m_len  out  2; m_addr, m_wdata  out  32; m_rdata  in  32 -- data-memory port (combinational read, write on clk edge).

Function
REQ-010 Size codes SHALL be 00 byte, 01 half, 10 word; 11 SHALL be treated as word.
REQ-011 Misaligned SHALL mean half with addr[0]=1, or word with addr[1:0]!=0.
REQ-012 FSM states SHALL be P_OWN (pipeline owns port) and D_OWN (debug owns port for exactly one cycle).
REQ-013 In P_OWN the m_* outputs SHALL carry the p_* request; m_we = p_req & p_we & ~misaligned; p_rdata = m_rdata combinationally; p_stall = 0.
REQ-014 In P_OWN with p_req=0 and d_req=1, the debug access SHALL be issued that same cycle (d_gnt=1), state unchanged.
REQ-015 Starvation counter SHALL increment each cycle d_req=1, p_req=1 in P_OWN; clear on any d_gnt or d_req=0; saturate at STARVE_MAX.
REQ-016 When counter = STARVE_MAX and d_req=1 and p_req=1, next state SHALL be D_OWN.
REQ-017 In D_OWN m_* SHALL carry the d_* request, d_gnt=1, p_stall=p_req, p_rdata=0; next state P_OWN unconditionally.
REQ-018 If d_req drops while in D_OWN, no access SHALL be issued (m_we=0, d_gnt=0), state still returns to P_OWN.
REQ-019 d_rdata/d_rvalid/d_err SHALL be registered: valid exactly one cycle after d_gnt, d_rdata = m_rdata sampled at grant, d_rvalid pulse 1 cycle.
REQ-020 p_err SHALL be combinational: p_req & misaligned in P_OWN; misaligned accesses SHALL never write memory for either requester.
REQ-021 Debug write SHALL return d_rvalid with d_rdata=0.
REQ-022 Back-to-back forced grants SHALL be separated by at least STARVE_MAX pipeline cycles (counter cleared on grant).
REQ-023 p_req and d_req both 0: m_we=0, m_addr=p_addr, no grant.

Reset
REQ-024 While rst=0: state P_OWN, counter 0, d_rvalid 0, d_rdata 0, d_err 0; combinational outputs follow P_OWN with p_req/d_req treated as 0 (m_we=0, d_gnt=0, p_stall=0).
REQ-025 Reset asserted during D_OWN SHALL abort the debug access (no write, no d_rvalid after release).
REQ-026 First grant decision after rst release SHALL occur on the first rising edge with rst=1.

Structure
REQ-027 Size codes, state encoding (P_OWN=0, D_OWN=1) and STARVE_MAX default SHALL live in shared package mem_pkg.
REQ-028 Misalignment detection SHALL be one sub-module align_check (len, addr[1:0] -> misaligned), instantiated twice.
REQ-029 Implementation SHALL be single-clock, no latches, no combinational loop from m_rdata to m_* outputs.

Verification
REQ-030 Pipeline word load addr 0x10 only, memory holds 0xDEADBEEF -> p_rdata=0xDEADBEEF same cycle, p_stall=0, d_gnt=0.
REQ-031 d_req write 0x55 addr 0x20 with p_req=0 -> d_gnt same cycle, memory[0x20]=0x55 next edge, d_rvalid=1 one cycle later.
REQ-032 p_req and d_req held continuously, STARVE_MAX=4 -> d_gnt after 4 pipeline cycles, p_stall=1 that cycle only, repeats every 5 cycles.
REQ-033 Pipeline word store addr 0x22 -> p_err=1, m_we=0, memory unchanged; debug half read addr 0x21 -> d_err=1 with d_rvalid.
REQ-034 rst=0 asserted mid-D_OWN -> m_we=0 immediately, d_rvalid stays 0, state P_OWN, counter 0 after release.
